// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
// Shares one burst memory command/data port between two requesters.
// RD is the display line prefetcher and normally has priority. WR is the
// camera writer and is guaranteed a turn after STARVE_LIMIT back-to-back RD
// grants. Only one burst is in flight at a time. The sequence is:
// arbitrate, present the command, stream the beats, then return to idle.

module fb_port_arbiter #(
    parameter int ADDR_W       = 25,
    parameter int LEN_W        = 8,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,

    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_done,

    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]  wr_len,
    output logic              wr_gnt,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_data_ack,
    output logic              wr_done,

    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LEN_W-1:0]  mem_len,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wdata_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_valid
);

    // The streak must hold 0..STARVE_LIMIT. The +2 keeps the width non-zero
    // even when STARVE_LIMIT is 0.
    localparam int STREAK_W = $clog2(STARVE_LIMIT + 2);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);
    localparam logic [LEN_W-1:0]    LEN_ONE    = LEN_W'(1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CMD     = 2'd1;
    localparam logic [1:0] WR_DATA = 2'd2;
    localparam logic [1:0] RD_DATA = 2'd3;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [LEN_W-1:0]    beat_cnt;
    logic [STREAK_W-1:0] streak;
    logic                rd_zero_done;
    logic                wr_zero_done;

    logic                arb_open;
    logic                pick_any;
    logic                pick_wr;
    logic [LEN_W-1:0]    pick_len;
    logic [ADDR_W-1:0]   pick_addr;
    logic                pick_zero;
    logic                cmd_accept;
    logic                rd_beat;
    logic                wr_beat;
    logic                last_beat;

    // Arbitration is held off while a grant pulse is showing. This matters
    // only for zero-length requests. In that case the requester still holds
    // its request during the pulse cycle, and it must not be granted twice.
    always_comb begin
        arb_open  = (state == IDLE) && !rd_gnt && !wr_gnt;
        pick_any  = arb_open && (rd_req || wr_req);
        pick_wr   = wr_req && (!rd_req || (streak == STREAK_MAX));
        pick_len  = pick_wr ? wr_len  : rd_len;
        pick_addr = pick_wr ? wr_addr : rd_addr;
        pick_zero = (pick_len == '0);
    end

    // Handshake and beat qualifiers. Beats are counted only in the
    // matching data state, so stray strobes never touch the counter.
    always_comb begin
        cmd_accept = (state == CMD) && mem_cmd_ready;
        rd_beat    = (state == RD_DATA) && mem_rdata_valid;
        wr_beat    = (state == WR_DATA) && mem_wdata_ready;
        last_beat  = (beat_cnt == LEN_ONE);
    end

    // Next-state logic for the single-burst sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_any && !pick_zero) begin
                    state_nxt = CMD;
                end
            end
            CMD: begin
                if (mem_cmd_ready) begin
                    state_nxt = mem_write ? WR_DATA : RD_DATA;
                end
            end
            WR_DATA: begin
                if (wr_beat && last_beat) begin
                    state_nxt = IDLE;
                end
            end
            RD_DATA: begin
                if (rd_beat && last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register. Reset abandons any burst in progress.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The command fields are captured from the winner at arbitration time.
    // They stay frozen until the memory accepts them, so the requester may
    // change its inputs once granted.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mem_cmd_valid <= 1'b0;
            mem_write     <= 1'b0;
            mem_addr      <= '0;
            mem_len       <= '0;
        end else if (pick_any && !pick_zero) begin
            mem_cmd_valid <= 1'b1;
            mem_write     <= pick_wr;
            mem_addr      <= pick_addr;
            mem_len       <= pick_len;
        end else if (cmd_accept) begin
            mem_cmd_valid <= 1'b0;
        end
    end

    // Grant pulses last one cycle. A zero-length winner gets its grant and
    // done together, and no memory command is issued for it.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rd_gnt       <= 1'b0;
            wr_gnt       <= 1'b0;
            rd_zero_done <= 1'b0;
            wr_zero_done <= 1'b0;
        end else begin
            rd_gnt       <= 1'b0;
            wr_gnt       <= 1'b0;
            rd_zero_done <= 1'b0;
            wr_zero_done <= 1'b0;
            if (pick_any && pick_zero) begin
                if (pick_wr) begin
                    wr_gnt       <= 1'b1;
                    wr_zero_done <= 1'b1;
                end else begin
                    rd_gnt       <= 1'b1;
                    rd_zero_done <= 1'b1;
                end
            end else if (cmd_accept) begin
                if (mem_write) begin
                    wr_gnt <= 1'b1;
                end else begin
                    rd_gnt <= 1'b1;
                end
            end
        end
    end

    // Beat counter. It is loaded with the burst length on command accept
    // and counts down one per transferred beat. The non-zero guard keeps it
    // from wrapping.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            beat_cnt <= '0;
        end else if (cmd_accept) begin
            beat_cnt <= mem_len;
        end else if ((rd_beat || wr_beat) && (beat_cnt != '0)) begin
            beat_cnt <= beat_cnt - LEN_ONE;
        end
    end

    // Starvation streak. It counts consecutive RD wins taken while WR was
    // waiting, and saturates at the limit. Any WR win clears it, and so does
    // an RD win with nobody waiting.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            streak <= '0;
        end else if (pick_any) begin
            if (pick_wr) begin
                streak <= '0;
            end else if (wr_req) begin
                if (streak != STREAK_MAX) begin
                    streak <= streak + STREAK_ONE;
                end
            end else begin
                streak <= '0;
            end
        end
    end

    // Data paths. They are transparent only in their own data state and
    // forced to zero everywhere else.
    always_comb begin
        rd_valid    = rd_beat;
        rd_data     = (state == RD_DATA) ? mem_rdata : '0;
        rd_done     = (rd_beat && last_beat) || rd_zero_done;
        wr_data_ack = wr_beat;
        mem_wdata   = (state == WR_DATA) ? wr_data : '0;
        wr_done     = (wr_beat && last_beat) || wr_zero_done;
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter
// Directed bench for fb_port_arbiter. A transaction-level reference model
// predicts every output on each cycle. Hand-computed literals pin the
// model and the DUT at the key points of each scenario.

module tb_fb_port_arbiter;

    localparam int ADDR_W       = 25;
    localparam int LEN_W        = 8;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 3;

    logic              clk_clk = 1'b0;
    logic              reset_reset_n;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  rd_len;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_done;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [LEN_W-1:0]  wr_len;
    logic              wr_gnt;
    logic [DATA_W-1:0] wr_data;
    logic              wr_data_ack;
    logic              wr_done;
    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LEN_W-1:0]  mem_len;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wdata_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdata_valid;

    fb_port_arbiter #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_gnt(rd_gnt),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_gnt(wr_gnt),
        .wr_data(wr_data), .wr_data_ack(wr_data_ack), .wr_done(wr_done),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_wdata(mem_wdata), .mem_wdata_ready(mem_wdata_ready),
        .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
    );

    always #5 clk_clk = ~clk_clk;

    // Reference model state: is a burst owned, is it still waiting for
    // the command handshake, its direction, and how many beats remain.
    bit                m_busy;
    bit                m_in_cmd;
    bit                m_dir_wr;
    bit                m_rd_gnt;
    bit                m_wr_gnt;
    bit                m_rd_zdone;
    bit                m_wr_zdone;
    logic [ADDR_W-1:0] m_addr;
    logic [LEN_W-1:0]  m_len;
    int                m_left;
    int                m_streak;
    int                model_glog[$];

    // Bookkeeping from the DUT side, written only by the stimulus process.
    int n_checks;
    int n_fail;
    int cnt_rd_valid;
    int cnt_rd_done;
    int cnt_rd_gnt;
    int cnt_wr_gnt;
    int cnt_ack;
    int cnt_wr_done;
    int cnt_cmd;
    int cnt_zero_pair;
    int dut_glog[$];

    // Reference model. It advances on each clock from the inputs the DUT
    // saw, applying the arbitration and burst rules directly.
    always @(posedge clk_clk or negedge reset_reset_n) begin : model
        bit nrg, nwg, nrz, nwz, take_wr, beat;
        int len;
        if (!reset_reset_n) begin
            m_busy = 0; m_in_cmd = 0; m_dir_wr = 0;
            m_rd_gnt = 0; m_wr_gnt = 0; m_rd_zdone = 0; m_wr_zdone = 0;
            m_addr = '0; m_len = '0; m_left = 0; m_streak = 0;
        end else begin
            nrg = 0; nwg = 0; nrz = 0; nwz = 0;
            if (!m_busy) begin
                if (!m_rd_gnt && !m_wr_gnt && (rd_req || wr_req)) begin
                    take_wr = wr_req && (!rd_req || m_streak == STARVE_LIMIT);
                    len = take_wr ? int'(wr_len) : int'(rd_len);
                    if (take_wr) m_streak = 0;
                    else if (wr_req) m_streak = (m_streak < STARVE_LIMIT) ? m_streak + 1 : STARVE_LIMIT;
                    else m_streak = 0;
                    if (len == 0) begin
                        model_glog.push_back(take_wr ? 1 : 0);
                        if (take_wr) begin nwg = 1; nwz = 1; end
                        else begin nrg = 1; nrz = 1; end
                    end else begin
                        m_busy = 1; m_in_cmd = 1; m_dir_wr = take_wr;
                        m_addr = take_wr ? wr_addr : rd_addr;
                        m_len  = take_wr ? wr_len : rd_len;
                    end
                end
            end else if (m_in_cmd) begin
                if (mem_cmd_ready) begin
                    m_in_cmd = 0;
                    m_left = int'(m_len);
                    model_glog.push_back(m_dir_wr ? 1 : 0);
                    if (m_dir_wr) nwg = 1; else nrg = 1;
                end
            end else begin
                beat = m_dir_wr ? mem_wdata_ready : mem_rdata_valid;
                if (beat) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_busy = 0;
                end
            end
            m_rd_gnt = nrg; m_wr_gnt = nwg; m_rd_zdone = nrz; m_wr_zdone = nwz;
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: wait bound expired, got no event, expected event", name);
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    task automatic compare_cycle();
        bit rd_ph, wr_ph, exp_cv;
        rd_ph  = m_busy && !m_in_cmd && !m_dir_wr;
        wr_ph  = m_busy && !m_in_cmd && m_dir_wr;
        exp_cv = m_busy && m_in_cmd;
        check_output("mem_cmd_valid", mem_cmd_valid, exp_cv);
        if (exp_cv) begin
            check_output("mem_write", mem_write, m_dir_wr);
            check_output("mem_addr", mem_addr, m_addr);
            check_output("mem_len", mem_len, m_len);
        end
        if (!reset_reset_n) begin
            check_output("rst_mem_addr", mem_addr, 0);
            check_output("rst_mem_len", mem_len, 0);
            check_output("rst_mem_write", mem_write, 0);
        end
        check_output("rd_gnt", rd_gnt, m_rd_gnt);
        check_output("wr_gnt", wr_gnt, m_wr_gnt);
        check_output("rd_valid", rd_valid, rd_ph && mem_rdata_valid);
        if (rd_ph) check_output("rd_data", rd_data, mem_rdata);
        check_output("rd_done", rd_done, (rd_ph && mem_rdata_valid && m_left == 1) || m_rd_zdone);
        check_output("wr_data_ack", wr_data_ack, wr_ph && mem_wdata_ready);
        if (wr_ph) check_output("mem_wdata", mem_wdata, wr_data);
        check_output("wr_done", wr_done, (wr_ph && mem_wdata_ready && m_left == 1) || m_wr_zdone);
        if (rd_valid === 1'b1) cnt_rd_valid++;
        if (rd_done === 1'b1) cnt_rd_done++;
        if (rd_gnt === 1'b1) begin cnt_rd_gnt++; dut_glog.push_back(0); end
        if (wr_gnt === 1'b1) begin cnt_wr_gnt++; dut_glog.push_back(1); end
        if (wr_data_ack === 1'b1) cnt_ack++;
        if (wr_done === 1'b1) cnt_wr_done++;
        if (mem_cmd_valid === 1'b1) cnt_cmd++;
        if (rd_gnt === 1'b1 && rd_done === 1'b1) cnt_zero_pair++;
    endtask

    task automatic tick();
        @(negedge clk_clk);
        compare_cycle();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle_inputs();
        rd_req = 0; rd_addr = '0; rd_len = '0;
        wr_req = 0; wr_addr = '0; wr_len = '0; wr_data = '0;
        mem_cmd_ready = 0; mem_wdata_ready = 0;
        mem_rdata = '0; mem_rdata_valid = 0;
    endtask

    task automatic apply_single_rd();
        int s_rv, s_rd, s_rg;
        s_rv = cnt_rd_valid; s_rd = cnt_rd_done; s_rg = cnt_rd_gnt;
        rd_addr = 25'h100; rd_len = 8'd4; rd_req = 1;
        tick();
        check_output("rd_cmd_valid", mem_cmd_valid, 1);
        check_output("rd_cmd_write", mem_write, 0);
        check_output("rd_cmd_addr", mem_addr, 64'h100);
        check_output("rd_cmd_len", mem_len, 4);
        ticks(2);
        mem_cmd_ready = 1;
        tick();
        check_output("rd_gnt_pulse", rd_gnt, 1);
        rd_req = 0; mem_cmd_ready = 0; rd_addr = 25'h3ff; rd_len = 8'd9;
        for (int b = 0; b < 4; b++) begin
            mem_rdata_valid = 1; mem_rdata = 32'hA000_0000 + b;
            tick();
            mem_rdata_valid = 0;
            tick();
        end
        ticks(2);
        check_output("rd_beats", cnt_rd_valid - s_rv, 4);
        check_output("rd_done_count", cnt_rd_done - s_rd, 1);
        check_output("rd_gnt_count", cnt_rd_gnt - s_rg, 1);
        idle_inputs();
    endtask

    task automatic apply_single_wr();
        int s_ack, s_wd, s_wg;
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        s_ack = cnt_ack; s_wd = cnt_wr_done; s_wg = cnt_wr_gnt;
        wr_addr = 25'h2000; wr_len = 8'd3; wr_req = 1; wr_data = 32'hC0DE_0000;
        mem_cmd_ready = 1;
        tick();
        check_output("wr_cmd_write", mem_write, 1);
        check_output("wr_cmd_addr", mem_addr, 64'h2000);
        check_output("wr_cmd_len", mem_len, 3);
        tick();
        check_output("wr_gnt_pulse", wr_gnt, 1);
        check_output("wr_mirror", mem_wdata, 64'hC0DE_0000);
        wr_req = 0; mem_cmd_ready = 0;
        for (int i = 0; i < 4; i++) begin
            mem_wdata_ready = pat[i];
            tick();
            if (pat[i]) wr_data = wr_data + 32'd1;
        end
        mem_wdata_ready = 0;
        ticks(2);
        check_output("wr_acks", cnt_ack - s_ack, 3);
        check_output("wr_done_count", cnt_wr_done - s_wd, 1);
        check_output("wr_gnt_count", cnt_wr_gnt - s_wg, 1);
        idle_inputs();
    endtask

    task automatic apply_contention();
        int s, ms, guard;
        int exp_pat[8];
        exp_pat = '{0, 0, 0, 1, 0, 0, 0, 1};
        s = dut_glog.size(); ms = model_glog.size();
        rd_addr = 25'h40; rd_len = 8'd1; wr_addr = 25'h80; wr_len = 8'd1;
        rd_req = 1; wr_req = 1;
        mem_cmd_ready = 1; mem_rdata_valid = 1; mem_wdata_ready = 1;
        mem_rdata = 32'h5555_AAAA; wr_data = 32'h1234_5678;
        guard = 0;
        while (dut_glog.size() < s + 8 && guard < 60) begin
            tick();
            guard++;
        end
        if (dut_glog.size() < s + 8) report_timeout("contention_grants");
        rd_req = 0; wr_req = 0;
        ticks(4);
        if (dut_glog.size() >= s + 8) begin
            for (int i = 0; i < 8; i++)
                check_output($sformatf("grant_order[%0d]", i), dut_glog[s + i], exp_pat[i]);
        end
        if (model_glog.size() >= ms + 8) begin
            for (int i = 0; i < 8; i++)
                check_output($sformatf("model_order[%0d]", i), model_glog[ms + i], exp_pat[i]);
        end else report_timeout("model_grants");
        idle_inputs();
    endtask

    task automatic apply_stray();
        int s_rv, s_rd, s_ack;
        s_rv = cnt_rd_valid; s_rd = cnt_rd_done; s_ack = cnt_ack;
        mem_rdata_valid = 1; mem_rdata = 32'hDEAD_BEEF; mem_wdata_ready = 1;
        ticks(2);
        rd_addr = 25'h300; rd_len = 8'd2; rd_req = 1;
        tick();
        check_output("stray_rd_valid_cmd", rd_valid, 0);
        check_output("stray_ack_cmd", wr_data_ack, 0);
        tick();
        mem_cmd_ready = 1;
        tick();
        rd_req = 0; mem_cmd_ready = 0; mem_rdata_valid = 0; mem_wdata_ready = 0;
        tick();
        mem_rdata_valid = 1; mem_rdata = 32'h0BAD_F00D;
        ticks(2);
        mem_rdata_valid = 0;
        ticks(2);
        check_output("stray_rd_beats", cnt_rd_valid - s_rv, 2);
        check_output("stray_rd_done", cnt_rd_done - s_rd, 1);
        check_output("stray_acks", cnt_ack - s_ack, 0);
        idle_inputs();
    endtask

    task automatic apply_reset_mid();
        int s_rv, s_rd;
        s_rv = cnt_rd_valid; s_rd = cnt_rd_done;
        rd_addr = 25'h500; rd_len = 8'd8; rd_req = 1; mem_cmd_ready = 1;
        ticks(2);
        rd_req = 0; mem_cmd_ready = 0;
        mem_rdata_valid = 1; mem_rdata = 32'h7777_0001;
        ticks(2);
        reset_reset_n = 0;
        #1;
        check_output("rst_cmd_valid_now", mem_cmd_valid, 0);
        check_output("rst_addr_now", mem_addr, 0);
        check_output("rst_len_now", mem_len, 0);
        check_output("rst_write_now", mem_write, 0);
        check_output("rst_rd_gnt_now", rd_gnt, 0);
        check_output("rst_wr_gnt_now", wr_gnt, 0);
        check_output("rst_rd_valid_now", rd_valid, 0);
        check_output("rst_rd_done_now", rd_done, 0);
        check_output("rst_rd_data_now", rd_data, 0);
        ticks(2);
        reset_reset_n = 1;
        ticks(6);
        mem_rdata_valid = 0;
        ticks(2);
        check_output("rst_rd_beats", cnt_rd_valid - s_rv, 2);
        check_output("rst_rd_done", cnt_rd_done - s_rd, 0);
        idle_inputs();
    endtask

    task automatic apply_zero_len();
        int s_cmd, s_pair, s, guard;
        int exp_pat[4];
        exp_pat = '{0, 0, 0, 1};
        s_cmd = cnt_cmd; s_pair = cnt_zero_pair;
        rd_req = 1; rd_len = 8'd0; rd_addr = 25'h600;
        tick();
        check_output("zero_rd_gnt", rd_gnt, 1);
        check_output("zero_rd_done", rd_done, 1);
        check_output("zero_no_cmd", mem_cmd_valid, 0);
        rd_req = 0;
        tick();
        check_output("zero_gnt_one_cycle", rd_gnt, 0);
        ticks(2);
        check_output("zero_cmd_cycles", cnt_cmd - s_cmd, 0);
        check_output("zero_pairs", cnt_zero_pair - s_pair, 1);

        s = dut_glog.size(); s_cmd = cnt_cmd; s_pair = cnt_zero_pair;
        rd_req = 1; rd_len = 8'd0;
        wr_req = 1; wr_addr = 25'h777; wr_len = 8'd1; wr_data = 32'h0000_CAFE;
        mem_cmd_ready = 1; mem_wdata_ready = 1;
        guard = 0;
        while (wr_gnt !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        if (wr_gnt !== 1'b1) report_timeout("zero_wr_gnt");
        rd_req = 0; wr_req = 0;
        ticks(4);
        if (dut_glog.size() >= s + 4) begin
            for (int i = 0; i < 4; i++)
                check_output($sformatf("zero_order[%0d]", i), dut_glog[s + i], exp_pat[i]);
        end else report_timeout("zero_grants");
        check_output("zero_streak_pairs", cnt_zero_pair - s_pair, 3);
        check_output("zero_wr_cmd_cycles", cnt_cmd - s_cmd, 1);
        idle_inputs();
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        cnt_rd_valid = 0; cnt_rd_done = 0; cnt_rd_gnt = 0; cnt_wr_gnt = 0;
        cnt_ack = 0; cnt_wr_done = 0; cnt_cmd = 0; cnt_zero_pair = 0;
        reset_reset_n = 1;
        idle_inputs();
        #2 reset_reset_n = 0;
        ticks(2);
        check_output("reset_cmd_valid", mem_cmd_valid, 0);
        check_output("reset_rd_gnt", rd_gnt, 0);
        check_output("reset_wr_gnt", wr_gnt, 0);
        reset_reset_n = 1;
        ticks(2);

        apply_single_rd();
        apply_single_wr();
        apply_contention();
        apply_stray();
        apply_reset_mid();
        apply_zero_len();
        ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
